// File: rtl/prog_freq_divider.sv
// prog_freq_divider: runtime-programmable integer clock divider.
// The divisor is loaded through a valid/ready handshake. A new divisor takes
// effect only at a period boundary, or one edge later when idle, so clk_out
// never produces a runt pulse. Dropping en lets the current period finish.
// Optional build macro FDIV_ODD_HALF_EN adds a negedge stage that gives odd
// divisors a 50% duty cycle.
module prog_freq_divider #(
    parameter int W       = 10,
    parameter int DIV_RST = 7
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_i,
    input  logic         div_vld,
    output logic         div_rdy,
    output logic [W-1:0] div_cur,
    output logic         clk_out,
    output logic         tick
);

    localparam logic [W-1:0] ZERO_C    = {W{1'b0}};
    localparam logic [W-1:0] ONE_C     = W'(1);
    localparam logic [W-1:0] TWO_C     = W'(2);
    localparam logic [W-1:0] DIV_RST_C = W'(DIV_RST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Divisors below 2 cannot form a period with both phases, so store 2.
    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        if (d < TWO_C) begin
            return TWO_C;
        end else begin
            return d;
        end
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   cnt_r;
    logic [W-1:0]   pend_r;
    logic           pend_vld_r;
    logic [W-1:0]   div_cur_r;
    logic           clk_p_r;
    logic           tick_r;

    logic [W-1:0]   cnt_nxt_s;
    logic           clk_p_nxt_s;
    logic           tick_nxt_s;
    logic           apply_s;
    logic           load_acc_s;
    logic           last_s;
    logic [W-1:0]   cnt_inc_s;
    logic [W-1:0]   half_s;

    // cnt never exceeds N-1 because the divisor only changes at cnt 0.
    assign last_s     = (cnt_r >= (div_cur_r - ONE_C));
    assign cnt_inc_s  = cnt_r + ONE_C;
    assign half_s     = div_cur_r >> 1;
    assign load_acc_s = div_vld & ~pend_vld_r;

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: start on en in IDLE, stop only at the end of a period.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s && !en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-state counter, output phase and divisor-apply decisions.
    always_comb begin
        cnt_nxt_s   = ZERO_C;
        clk_p_nxt_s = 1'b0;
        tick_nxt_s  = 1'b0;
        apply_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                apply_s = pend_vld_r;
                if (en) begin
                    clk_p_nxt_s = 1'b1;
                    tick_nxt_s  = 1'b1;
                end else begin
                    clk_p_nxt_s = 1'b0;
                    tick_nxt_s  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!last_s) begin
                    cnt_nxt_s   = cnt_inc_s;
                    clk_p_nxt_s = (cnt_inc_s < half_s);
                end else if (en) begin
                    clk_p_nxt_s = 1'b1;
                    tick_nxt_s  = 1'b1;
                    apply_s     = pend_vld_r;
                end else begin
                    clk_p_nxt_s = 1'b0;
                end
            end
            default: begin
                cnt_nxt_s   = ZERO_C;
                clk_p_nxt_s = 1'b0;
            end
        endcase
    end

    // Counter and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r   <= ZERO_C;
            clk_p_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            clk_p_r <= clk_p_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    // Divisor handshake: an accepted load outranks the apply-clear of pend_vld.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_cur_r  <= DIV_RST_C;
            pend_r     <= ZERO_C;
            pend_vld_r <= 1'b0;
        end else begin
            if (apply_s) begin
                div_cur_r  <= pend_r;
                pend_vld_r <= 1'b0;
            end else begin
                div_cur_r  <= div_cur_r;
            end
            if (load_acc_s) begin
                pend_r     <= clamp_div(div_i);
                pend_vld_r <= 1'b1;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

`ifdef FDIV_ODD_HALF_EN
    logic clk_n_r;

    // Half-cycle delayed copy of clk_p stretches odd high phases by half a cycle.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            clk_n_r <= 1'b0;
        end else begin
            clk_n_r <= clk_p_r;
        end
    end

    assign clk_out = clk_p_r | (div_cur_r[0] & clk_n_r);
`else
    assign clk_out = clk_p_r;
`endif

    assign div_rdy = ~pend_vld_r;
    assign div_cur = div_cur_r;
    assign tick    = tick_r;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed self-checking bench for prog_freq_divider (W=10, DIV_RST=7).
// Outputs are sampled 1 time unit after each rising clk_in edge.
module tb_prog_freq_divider;

    logic       clk_in;
    logic       rst;
    logic       en;
    logic [9:0] div_i;
    logic       div_vld;
    logic       div_rdy;
    logic [9:0] div_cur;
    logic       clk_out;
    logic       tick;

    int checks;
    int errors;

    logic [63:0] cap_c;
    logic [63:0] cap_t;
    logic [63:0] cap_r;

`ifdef FDIV_ODD_HALF_EN
    localparam int ODD_EXTRA = 1;
`else
    localparam int ODD_EXTRA = 0;
`endif

    prog_freq_divider #(.W(10), .DIV_RST(7)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_i   (div_i),
        .div_vld (div_vld),
        .div_rdy (div_rdy),
        .div_cur (div_cur),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Number of post-edge samples in which clk_out reads high for divisor n.
    function automatic int hi_of(input int n);
        return (n / 2) + (((n % 2) == 1) ? ODD_EXTRA : 0);
    endfunction

    // Expected clk_out samples: n samples starting at counter value start.
    function automatic logic [63:0] wave_clk(input int n, input int nd, input int start);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < n; i++) begin
            w[i] = (((start + i) % nd) < hi_of(nd));
        end
        return w;
    endfunction

    // Expected tick samples: high where the counter is 0.
    function automatic logic [63:0] wave_tick(input int n, input int nd, input int start);
        logic [63:0] w;
        w = 64'd0;
        for (int i = 0; i < n; i++) begin
            w[i] = (((start + i) % nd) == 0);
        end
        return w;
    endfunction

    function automatic logic [63:0] ones(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int n);
        cap_c = 64'd0;
        cap_t = 64'd0;
        cap_r = 64'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            cap_c[i] = clk_out;
            cap_t[i] = tick;
            cap_r[i] = div_rdy;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        div_i   = 10'd0;
        div_vld = 1'b0;
        #1;
        chk("rst_clk_out", 64'(clk_out), 64'd0);
        chk("rst_tick",    64'(tick),    64'd0);
        chk("rst_div_rdy", 64'(div_rdy), 64'd1);
        chk("rst_div_cur", 64'(div_cur), 64'd7);
        @(posedge clk_in);
        #1;
        rst = 1'b0;

        // Default divisor 7, three periods.
        en = 1'b1;
        capture(21);
        chk("n7_clk",  cap_c, wave_clk(21, 7, 0));
        chk("n7_tick", cap_t, wave_tick(21, 7, 0));
        chk("n7_div_cur", 64'(div_cur), 64'd7);

        // Stop at the last count: straight to IDLE, output stays low.
        en = 1'b0;
        capture(3);
        chk("idle_clk",  cap_c, 64'd0);
        chk("idle_tick", cap_t, 64'd0);

        // Load 4 in IDLE: effective one edge after acceptance.
        div_i = 10'd4; div_vld = 1'b1;
        capture(1);
        chk("idle_load_rdy", 64'(div_rdy), 64'd0);
        chk("idle_load_cur", 64'(div_cur), 64'd7);
        div_vld = 1'b0;
        capture(1);
        chk("idle_apply_cur", 64'(div_cur), 64'd4);
        chk("idle_apply_rdy", 64'(div_rdy), 64'd1);

        // Run N=4, load 10 at cnt 1: period completes, then 5/5 periods of 10.
        en = 1'b1;
        capture(6);
        chk("n4_clk",  cap_c, wave_clk(6, 4, 0));
        chk("n4_tick", cap_t, wave_tick(6, 4, 0));
        div_i = 10'd10; div_vld = 1'b1;
        capture(1);
        chk("run_load_rdy", 64'(div_rdy), 64'd0);
        chk("run_load_cur", 64'(div_cur), 64'd4);
        chk("run_load_clk", 64'(clk_out), 64'd0);
        div_vld = 1'b0;
        capture(1);
        chk("n4_tail", {cap_r[0], cap_t[0], cap_c[0]}, 64'd0);
        capture(20);
        chk("n10_clk",  cap_c, wave_clk(20, 10, 0));
        chk("n10_tick", cap_t, wave_tick(20, 10, 0));
        chk("n10_rdy",  cap_r, ones(20));
        chk("n10_cur",  64'(div_cur), 64'd10);

        // Load 0 on the wrap edge: clamps to 2 at the following wrap.
        div_i = 10'd0; div_vld = 1'b1;
        capture(1);
        chk("ld0_rdy", 64'(div_rdy), 64'd0);
        chk("ld0_start", {cap_t[0], cap_c[0]}, 64'd3);
        div_vld = 1'b0;
        capture(9);
        chk("ld0_n10_clk", cap_c, wave_clk(9, 10, 1));
        capture(6);
        chk("n2a_clk",  cap_c, wave_clk(6, 2, 0));
        chk("n2a_tick", cap_t, wave_tick(6, 2, 0));
        chk("n2a_cur",  64'(div_cur), 64'd2);

        // Load 1: also clamps to 2.
        div_i = 10'd1; div_vld = 1'b1;
        capture(1);
        chk("ld1_rdy", 64'(div_rdy), 64'd0);
        div_vld = 1'b0;
        capture(1);
        capture(4);
        chk("n2b_clk",  cap_c, wave_clk(4, 2, 0));
        chk("n2b_tick", cap_t, wave_tick(4, 2, 0));
        chk("n2b_rdy",  cap_r, ones(4));
        chk("n2b_cur",  64'(div_cur), 64'd2);

        // Switch to 6, drop en at cnt 1: period completes then IDLE.
        div_i = 10'd6; div_vld = 1'b1;
        capture(1);
        div_vld = 1'b0;
        capture(1);
        capture(2);
        chk("n6_head_clk",  cap_c, 64'b11);
        chk("n6_head_tick", cap_t, 64'b01);
        chk("n6_cur", 64'(div_cur), 64'd6);
        en = 1'b0;
        capture(7);
        chk("n6_stop_clk",  cap_c, 64'b0000001);
        chk("n6_stop_tick", cap_t, 64'd0);
        en = 1'b1;
        capture(1);
        chk("n6_restart", {cap_t[0], cap_c[0]}, 64'd3);
        capture(5);
        chk("n6_rest_clk", cap_c, wave_clk(5, 6, 1));

        // Asynchronous reset in the high phase, with no clock edge in between.
        capture(1);
        chk("pre_rst_clk", {cap_t[0], cap_c[0]}, 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", 64'(clk_out), 64'd0);
        chk("arst_tick",    64'(tick),    64'd0);
        chk("arst_div_rdy", 64'(div_rdy), 64'd1);
        chk("arst_div_cur", 64'(div_cur), 64'd7);
        en = 1'b0;
        #1;
        rst = 1'b0;
        capture(2);
        chk("post_rst_idle", cap_c | cap_t, 64'd0);

        // Back-to-back loads 5 then 9 in one period of 7.
        en = 1'b1;
        capture(1);
        div_i = 10'd5; div_vld = 1'b1;
        capture(1);
        chk("b2b_first_rdy", 64'(div_rdy), 64'd0);
        div_i = 10'd9;
        capture(5);
        chk("b2b_stall_rdy", cap_r, 64'd0);
        chk("b2b_n7_clk", cap_c, wave_clk(5, 7, 2));
        chk("b2b_n7_cur", 64'(div_cur), 64'd7);
        capture(1);
        chk("b2b_n5_start", {cap_r[0], cap_t[0], cap_c[0]}, 64'd7);
        chk("b2b_n5_cur", 64'(div_cur), 64'd5);
        capture(1);
        chk("b2b_second_rdy", 64'(div_rdy), 64'd0);
        div_vld = 1'b0;
        capture(3);
        chk("b2b_n5_clk", cap_c, wave_clk(3, 5, 2));
        capture(18);
        chk("b2b_n9_clk",  cap_c, wave_clk(18, 9, 0));
        chk("b2b_n9_tick", cap_t, wave_tick(18, 9, 0));
        chk("b2b_n9_rdy",  cap_r, ones(18));
        chk("b2b_n9_cur",  64'(div_cur), 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
